// File: rtl/slot_mixer_pkg.sv
// slot_mixer_pkg: shared frame geometry, rhythm slot numbers and FSM states for the slot mixer.
package slot_mixer_pkg;
  localparam int FRAME_LEN = 72;
  localparam int LAST_SLOT = 17;
  localparam int SAMPLE_STAGE = 3;
  localparam int MELODY_RHYTHM_LAST = 11;
  localparam int BD = 13;
  localparam int HH = 14;
  localparam int SD = 15;
  localparam int TOM = 16;
  localparam int CYM = 17;
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
endpackage

// File: rtl/slot_route.sv
// slot_route: decodes (slot, stage, rhythm) into melody/rhythm accumulator selects.
module slot_route
  import slot_mixer_pkg::*;
(
  input  logic [4:0] slot,
  input  logic [1:0] stage,
  input  logic       rhythm,
  output logic       to_melody,
  output logic       to_rhythm
);
  logic sample;
  assign sample = stage == 2'(SAMPLE_STAGE);
  always_comb begin
    to_melody = sample && slot[0] && slot <= (rhythm ? 5'(MELODY_RHYTHM_LAST) : 5'(LAST_SLOT));
    to_rhythm = sample && rhythm && slot >= 5'(BD) && slot <= 5'(CYM);
  end
endmodule

// File: rtl/slot_mixer.sv
// slot_mixer: accumulates per-slot operator outputs into melody/rhythm frame sums,
// tracking the slot/stage sequence and dropping to HUNT on any violation.
module slot_mixer
  import slot_mixer_pkg::*;
#(
  parameter int OPW = 10,
  parameter int ACW = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clkena,
  input  logic [4:0]            slot,
  input  logic [1:0]            stage,
  input  logic signed [OPW-1:0] op_out,
  input  logic                  rhythm,
  output logic signed [ACW-1:0] melody_out,
  output logic signed [ACW-1:0] rhythm_out,
  output logic signed [15:0]    mix_out,
  output logic                  sample_valid,
  output logic                  seq_err
);
  logic [0:0] state;
  logic [6:0] exp_pos;
  logic [6:0] pos;
  logic signed [ACW-1:0] mel_acc, rhy_acc, ext, mel_nxt, rhy_nxt;
  logic signed [15:0] mix_nxt;
  logic to_mel, to_rhy, last;
  slot_route u_route (
    .slot      (slot),
    .stage     (stage),
    .rhythm    (rhythm),
    .to_melody (to_mel),
    .to_rhythm (to_rhy)
  );
  // exp_pos never exceeds 71, so slot>17 can never match it
  assign pos = {slot, stage};
  assign last = exp_pos == 7'(FRAME_LEN - 1);
  assign ext = {{(ACW-OPW){op_out[OPW-1]}}, op_out};
  assign mel_nxt = mel_acc + (to_mel ? ext : '0);
  assign rhy_nxt = rhy_acc + (to_rhy ? ext : '0);
  assign mix_nxt = 16'(mel_nxt) + 16'(rhy_nxt) + 16'(rhy_nxt);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HUNT;
      exp_pos <= '0;
      mel_acc <= '0;
      rhy_acc <= '0;
      melody_out <= '0;
      rhythm_out <= '0;
      mix_out <= '0;
      sample_valid <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (clkena) begin
        if (state == HUNT) begin
          if (pos == '0) begin
            state <= RUN;
            exp_pos <= 7'd1;
          end
        end else if (pos == exp_pos) begin
          if (last) begin
            melody_out <= mel_nxt;
            rhythm_out <= rhy_nxt;
            mix_out <= mix_nxt;
            sample_valid <= 1'b1;
            mel_acc <= '0;
            rhy_acc <= '0;
            exp_pos <= '0;
          end else begin
            mel_acc <= mel_nxt;
            rhy_acc <= rhy_nxt;
            exp_pos <= exp_pos + 7'd1;
          end
        end else begin
          seq_err <= 1'b1;
          mel_acc <= '0;
          rhy_acc <= '0;
          state <= HUNT;
          exp_pos <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_slot_mixer.sv
// tb_slot_mixer: table vectors, hand-written corner sequences and random frames against a slot-rule model.
module tb_slot_mixer;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clkena = 1'b0;
  logic [4:0] slot = '0;
  logic [1:0] stage = '0;
  logic signed [9:0] op_out = '0;
  logic rhythm = 1'b0;
  logic signed [13:0] melody_out, rhythm_out;
  logic signed [15:0] mix_out;
  logic sample_valid, seq_err;

  slot_mixer #(.OPW(10), .ACW(14)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clkena       (clkena),
    .slot         (slot),
    .stage        (stage),
    .op_out       (op_out),
    .rhythm       (rhythm),
    .melody_out   (melody_out),
    .rhythm_out   (rhythm_out),
    .mix_out      (mix_out),
    .sample_valid (sample_valid),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lo;
    int hi;
    bit rh;
    int mel;
    int rhy;
    int mix;
  } vec_t;

  int ops[18];
  bit rhs[18];
  int pass_cnt = 0;
  int chk_cnt = 0;
  int sv_cnt = 0;

  always @(negedge clk) if (sample_valid) sv_cnt++;

  task automatic chk(string n, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  task automatic put(int s, int st, int op, bit rh, bit ena);
    slot = 5'(s);
    stage = 2'(st);
    op_out = 10'(op);
    rhythm = rh;
    clkena = ena;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    put($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 1023) - 512, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic run_pos(int from, int to, int gmin, int gmax);
    for (int p = from; p <= to; p++) begin
      repeat ($urandom_range(gmin, gmax)) idle();
      put(p / 4, p % 4, (p % 4 == 3) ? ops[p / 4] : $urandom_range(0, 1023) - 512, rhs[p / 4], 1'b1);
    end
  endtask

  // Reference: carriers are odd slots; in rhythm mode slots 13..17 go to rhythm and 12 is dropped
  task automatic model(output int m, output int r);
    m = 0;
    r = 0;
    for (int s = 0; s < 18; s++) begin
      if (!rhs[s]) begin
        if (s % 2 == 1) m += ops[s];
      end else if (s >= 13) r += ops[s];
      else if (s % 2 == 1) m += ops[s];
    end
  endtask

  task automatic frame(string n, int gmin, int gmax, int m, int r, int x);
    int sv0;
    sv0 = sv_cnt;
    run_pos(0, 71, gmin, gmax);
    chk({n, " valid"}, int'(sample_valid), 1);
    chk({n, " melody"}, int'(melody_out), m);
    chk({n, " rhythm"}, int'(rhythm_out), r);
    chk({n, " mix"}, int'(mix_out), x);
    idle();
    chk({n, " valid_low"}, int'(sample_valid), 0);
    chk({n, " pulses"}, sv_cnt - sv0, 1);
  endtask

  task automatic fill(int lo, int hi, bit rh);
    for (int s = 0; s < 18; s++) begin
      ops[s] = (s <= 11) ? lo : hi;
      rhs[s] = rh;
    end
  endtask

  initial begin
    vec_t vecs[5];
    int m, r, sv0;
    vecs[0] = '{100, 100, 1'b0, 900, 0, 900};
    vecs[1] = '{10, 20, 1'b1, 60, 100, 260};
    vecs[2] = '{-512, -512, 1'b0, -4608, 0, -4608};
    vecs[3] = '{511, -512, 1'b1, 3066, -2560, -2054};
    vecs[4] = '{-1, 7, 1'b0, 15, 0, 15};

    #2 reset_n = 1'b0;
    #1;
    chk("rst melody", int'(melody_out), 0);
    chk("rst rhythm", int'(rhythm_out), 0);
    chk("rst mix", int'(mix_out), 0);
    chk("rst valid", int'(sample_valid), 0);
    chk("rst seq_err", int'(seq_err), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    foreach (vecs[i]) begin
      fill(vecs[i].lo, vecs[i].hi, vecs[i].rh);
      frame($sformatf("vec%0d", i), 0, 0, vecs[i].mel, vecs[i].rhy, vecs[i].mix);
    end
    chk("seq_err clean", int'(seq_err), 0);

    // jump 30 -> 35 mid-frame
    fill(100, 100, 1'b0);
    sv0 = sv_cnt;
    run_pos(0, 30, 0, 0);
    put(8, 3, 100, 1'b0, 1'b1);
    chk("jump seq_err", int'(seq_err), 1);
    chk("jump valid", int'(sample_valid), 0);
    run_pos(36, 71, 0, 0);
    idle();
    chk("jump pulses", sv_cnt - sv0, 0);
    chk("jump hold melody", int'(melody_out), 15);
    chk("jump hold mix", int'(mix_out), 15);
    frame("resync", 0, 0, 900, 0, 900);
    chk("sticky seq_err", int'(seq_err), 1);

    // async reset at slot 9 stage 2
    sv0 = sv_cnt;
    run_pos(0, 38, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst melody", int'(melody_out), 0);
    chk("arst mix", int'(mix_out), 0);
    chk("arst seq_err", int'(seq_err), 0);
    chk("arst valid", int'(sample_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_pos(39, 71, 0, 0);
    idle();
    chk("arst pulses", sv_cnt - sv0, 0);
    chk("arst hunt melody", int'(melody_out), 0);
    fill(10, 20, 1'b1);
    frame("post_rst", 0, 0, 60, 100, 260);
    chk("post_rst seq_err", int'(seq_err), 0);

    // slot out of range is a violation
    put(18, 0, 0, 1'b0, 1'b1);
    chk("slot18 seq_err", int'(seq_err), 1);

    fill(100, 100, 1'b0);
    frame("ena1of3", 2, 2, 900, 0, 900);

    for (int k = 0; k < 15; k++) begin
      for (int s = 0; s < 18; s++) begin
        ops[s] = $urandom_range(0, 1023) - 512;
        rhs[s] = 1'($urandom_range(0, 1));
      end
      model(m, r);
      frame($sformatf("rand%0d", k), 0, 2, m, r, m + 2 * r);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/slot_mixer.md
SLOT_MIXER -- requirements
Module: slot_mixer

Interface
REQ-001 Parameter OPW, 10: signed width of the per-slot operator output.
REQ-002 Parameter ACW, 14: accumulator width; sized so the sum of nine full-scale OPW samples cannot overflow.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 clkena  in  1  slot-time enable; slot, stage and op_out are sampled only when clkena=1.
REQ-006 slot  in  5  current slot 0..17, from the slot-sequencing counter.
REQ-007 stage  in  2  current stage 0..3 within the slot.
REQ-008 op_out  in  OPW  signed operator output for the current slot; valid when stage=3.
REQ-009 rhythm  in  1  rhythm-mode enable; sampled with each accepted contribution.
REQ-010 melody_out  out  ACW  signed sum of melody carriers for the last complete frame.
REQ-011 rhythm_out  out  ACW  signed sum of rhythm voices for the last complete frame.
REQ-012 mix_out  out  16  signed value equal to melody_out + 2*rhythm_out for the last complete frame.
REQ-013 sample_valid  out  1  one-clk pulse each time new frame results are presented.
REQ-014 seq_err  out  1  sticky flag set on a slot/stage sequence violation.

Function
REQ-015 The slot position is {slot,stage}, counting 0..71 per frame; a frame ends at position 71 (slot 17, stage 3).
REQ-016 The block has two states: HUNT and RUN; it enters HUNT on reset.
REQ-017 HUNT->RUN when clkena=1 and slot=0 and stage=0; the block ignores all other inputs in HUNT.
REQ-018 In RUN, each clkena=1 cycle shall present the previous position+1, with 71 wrapping to 0; any other value, including slot>17, is a violation.
REQ-019 On a violation: set seq_err, clear both accumulators, go to HUNT, emit no sample_valid, and keep the output registers unchanged.
REQ-020 A contribution is accepted only in RUN, with clkena=1, stage=3, a legal position and a carrier slot.
REQ-021 With rhythm=0, the carrier slots are the odd slots 1..17, and all are added to the melody accumulator.
REQ-022 With rhythm=1, odd slots 1..11 are added to the melody accumulator; slots 13, 14, 15, 16 and 17 are added to the rhythm accumulator; slot 12 is ignored.
REQ-023 Accumulation is signed and sign-extends OPW to ACW; no saturation is needed (max |sum| 9*2^(OPW-1)).
REQ-024 At position 71 with clkena=1, the clk edge shall load melody_out, rhythm_out and mix_out with the final sums, including slot 17's contribution on that same edge.
REQ-025 On that same edge, both accumulators clear to 0.
REQ-026 sample_valid is high for exactly the one clk cycle following the REQ-024 edge, regardless of the next clkena.
REQ-027 The first frame after HUNT->RUN is complete (RUN entered at position 0), so its result is emitted.
REQ-028 clkena=0 cycles hold all state; sample_valid still deasserts after one cycle.
REQ-029 A change of rhythm mid-frame takes effect per slot at the time each contribution is accepted.
REQ-030 Output latency is 1 clk from the position-71 accept to the registered outputs and sample_valid.

Reset
REQ-031 When reset_n=0: state=HUNT, accumulators=0, melody_out=rhythm_out=mix_out=0, sample_valid=0, seq_err=0, expected position=0.
REQ-032 Reset asserted mid-frame discards the partial frame; no sample_valid is produced for it.
REQ-033 Only reset clears seq_err.

Structure
REQ-034 A shared package holds: the frame length constant (72), last slot (17), stage-of-sample (3), the rhythm slot numbers (BD=13, HH=14, SD=15, TOM=16, CYM=17), and the state enum {HUNT,RUN}.
REQ-035 One sub-module, slot_route, is natural: a combinational decode of (slot, stage, rhythm) to {to_melody, to_rhythm}.

Verification
REQ-036 Scenario: reset, then a legal sequence from position 0 with rhythm=0 and op_out=+100 on all stage-3 slots -> one clk after position 71, melody_out=900, rhythm_out=0, mix_out=900, and sample_valid is a single pulse.
REQ-037 Scenario: rhythm=1, op_out=+10 on odd slots <=11, +20 on slots 12..17 -> melody_out=60, rhythm_out=100, mix_out=260.
REQ-038 Scenario: op_out=-512 on every slot, rhythm=0 -> melody_out=-4608, with no wrap.
REQ-039 Scenario: jump from position 30 to 35 mid-frame -> seq_err=1, no sample_valid; after re-sync at position 0, the next full frame gives correct sums and seq_err remains 1.
REQ-040 Scenario: pull reset_n low at slot 9 stage 2 -> all outputs 0 asynchronously, no sample_valid, and HUNT until position 0.
REQ-041 Scenario: clkena toggling 1-of-3 cycles over a full frame -> same sums as the continuous-enable run, with sample_valid exactly 1 clk wide.
